// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan monitor: glyph table,
// blank glyph, scan FSM states and the decoder result record.
package seg_pkg;

    localparam int NUM_DIGITS_DEF = 8;

    // Active-high gfedcba glyphs; entry i is the glyph for nibble i.
    localparam logic [15:0][6:0] GLYPH_TBL = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic       hit;
        logic       blank;
        logic [3:0] nibble;
    } glyph_dec_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational active-high glyph to {hit, blank, nibble} decoder.
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] glyph,
    output glyph_dec_t dec
);

    always_comb begin
        dec       = '0;
        dec.blank = (glyph == GLYPH_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (glyph == GLYPH_TBL[i]) begin
                dec.hit    = 1'b1;
                dec.nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment scan, debounces each
// dwell and rebuilds the decoded digit frame with validity and fault flags.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = NUM_DIGITS_DEF,
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 65536
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_DIGITS-1:0]     an_in,
    input  logic [6:0]                seg_in,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_valid,
    output logic [NUM_DIGITS-1:0]     bad_pattern,
    output logic                      scan_timeout
);

    localparam int CNT_W  = 4;
    localparam int IDLE_W = $clog2(FRAME_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_CAP   = CNT_W'(STABLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(FRAME_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FRAME_TIMEOUT - 1);

    logic [NUM_DIGITS-1:0] r_an, p_an;
    logic [6:0]            r_seg, p_seg;
    scan_state_e           state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [NUM_DIGITS-1:0] seen_mask;
    logic [IDLE_W-1:0]     idle_cnt;

    logic [NUM_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0] mask_set;
    logic                  an_legal;
    logic                  pair_same;
    logic                  capture;
    glyph_dec_t            dec;

    assign sel       = ~r_an;
    assign an_legal  = $onehot(sel);
    assign pair_same = (r_an == p_an) && (r_seg == p_seg);
    assign mask_set  = seen_mask | sel;

    seg7_to_hex u_dec (
        .glyph (~r_seg),
        .dec   (dec)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BLANK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A changed pair restarts the dwell; only SETTLE can capture, so each
    // dwell yields at most one capture.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            BLANK: begin
                if (an_legal) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            SETTLE: begin
                if (!pair_same) begin
                    state_nxt = an_legal ? SETTLE : BLANK;
                    cnt_nxt   = an_legal ? CNT_W'(1) : '0;
                end else if (cnt + CNT_W'(1) == CNT_CAP) begin
                    state_nxt = HELD;
                    cnt_nxt   = CNT_CAP;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!pair_same) begin
                    state_nxt = an_legal ? SETTLE : BLANK;
                    cnt_nxt   = an_legal ? CNT_W'(1) : '0;
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_an         <= '1;
            r_seg        <= '0;
            p_an         <= '1;
            p_seg        <= '0;
            digits       <= '0;
            digit_valid  <= '0;
            frame_valid  <= 1'b0;
            bad_pattern  <= '0;
            scan_timeout <= 1'b0;
            seen_mask    <= '0;
            idle_cnt     <= '0;
        end else begin
            r_an        <= an_in;
            r_seg       <= seg_in;
            p_an        <= r_an;
            p_seg       <= r_seg;
            frame_valid <= 1'b0;

            // Capture takes priority over a timeout landing on the same edge.
            if (capture) begin
                idle_cnt     <= '0;
                scan_timeout <= 1'b0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        if (dec.hit) begin
                            digits[4*i +: 4] <= dec.nibble;
                            digit_valid[i]   <= 1'b1;
                        end else if (dec.blank) begin
                            digits[4*i +: 4] <= 4'h0;
                            digit_valid[i]   <= 1'b0;
                        end else begin
                            bad_pattern[i]   <= 1'b1;
                            digit_valid[i]   <= 1'b0;
                        end
                    end
                end
                if (&mask_set) begin
                    frame_valid <= 1'b1;
                    seen_mask   <= '0;
                end else begin
                    seen_mask   <= mask_set;
                end
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                if (idle_cnt == IDLE_LAST) begin
                    scan_timeout <= 1'b1;
                    digit_valid  <= '0;
                    seen_mask    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scoreboard bench for seg_scan_decoder (STABLE_CYCLES=4, FRAME_TIMEOUT=64).
module tb_seg_scan_decoder;

    localparam int ND = 8;
    localparam int SC = 4;
    localparam int FT = 64;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [ND-1:0]   an_in = '1;
    logic [6:0]      seg_in = 7'h7F;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   digit_valid;
    logic            frame_valid;
    logic [ND-1:0]   bad_pattern;
    logic            scan_timeout;

    seg_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .FRAME_TIMEOUT (FT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .an_in        (an_in),
        .seg_in       (seg_in),
        .digits       (digits),
        .digit_valid  (digit_valid),
        .frame_valid  (frame_valid),
        .bad_pattern  (bad_pattern),
        .scan_timeout (scan_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] dig;
        logic [7:0]  vld;
        logic [7:0]  bad;
        int          frames;
        logic        to;
    } exp_t;

    exp_t sb[$];

    logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [31:0] m_dig  = '0;
    logic [7:0]  m_vld  = '0;
    logic [7:0]  m_bad  = '0;
    logic [7:0]  m_mask = '0;
    int          m_frames = 0;
    logic        m_to = 1'b0;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int frame_cnt = 0;

    always @(negedge clock) if (frame_valid) frame_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_capture(input int d, input logic [6:0] g);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (gl[k] == g) begin
                hit = 1'b1;
                m_dig[4*d +: 4] = 4'(k);
            end
        end
        if (hit) m_vld[d] = 1'b1;
        else if (g == 7'h00) begin
            m_vld[d] = 1'b0;
            m_dig[4*d +: 4] = 4'h0;
        end else begin
            m_vld[d] = 1'b0;
            m_bad[d] = 1'b1;
        end
        m_mask[d] = 1'b1;
        m_to = 1'b0;
        if (m_mask == 8'hFF) begin
            m_frames++;
            m_mask = '0;
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.dig = m_dig; e.vld = m_vld; e.bad = m_bad; e.frames = m_frames; e.to = m_to;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "_dig"},   digits,            e.dig);
        chk({tag, "_vld"},   32'(digit_valid),  32'(e.vld));
        chk({tag, "_bad"},   32'(bad_pattern),  32'(e.bad));
        chk({tag, "_frame"}, 32'(frame_cnt),    32'(e.frames));
        chk({tag, "_to"},    32'(scan_timeout), 32'(e.to));
    endtask

    // Holds one anode/glyph pair for cyc samples; dwells longer than SC capture.
    task automatic dwell(input int d, input logic [6:0] g, input int cyc, input string tag);
        logic [7:0] one;
        one = 8'd1;
        an_in  = ~(one << d);
        seg_in = ~g;
        if (cyc > SC) model_capture(d, g);
        push_model();
        repeat (cyc) @(negedge clock);
        sb_check(tag);
    endtask

    task automatic hold_raw(input logic [7:0] an, input logic [6:0] seg, input int cyc, input string tag);
        an_in  = an;
        seg_in = seg;
        if (cyc >= FT) begin
            m_to   = 1'b1;
            m_vld  = '0;
            m_mask = '0;
        end
        push_model();
        repeat (cyc) @(negedge clock);
        sb_check(tag);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_dig", digits, 32'h0);
        chk("rst_vld", 32'(digit_valid), 32'h0);
        chk("rst_fv",  32'(frame_valid), 32'h0);
        chk("rst_bad", 32'(bad_pattern), 32'h0);
        chk("rst_to",  32'(scan_timeout), 32'h0);

        // Capture latency: visible exactly SC edges after first sample
        reset  = 1'b0;
        an_in  = 8'hFE;
        seg_in = ~7'h06;
        repeat (SC) @(negedge clock);
        chk("lat_early_vld", 32'(digit_valid[0]), 32'h0);
        chk("lat_early_dig", 32'(digits[3:0]), 32'h0);
        an_in  = 8'hFF;
        seg_in = 7'h7F;
        @(negedge clock);
        chk("lat_dig", 32'(digits[3:0]), 32'h1);
        chk("lat_vld", 32'(digit_valid[0]), 32'h1);
        m_dig[3:0] = 4'h1; m_vld[0] = 1'b1; m_mask[0] = 1'b1;
        repeat (2) @(negedge clock);
        chk("lat_no_frame", 32'(frame_cnt), 32'h0);

        // Two full scans: 7..0 on digits 0..7
        for (int s = 0; s < 2; s++)
            for (int d = 0; d < ND; d++)
                dwell(d, gl[7-d], 8, $sformatf("scan%0d_d%0d", s, d));
        chk("scan_digits", digits, 32'h01234567);

        // Short dwell on digit 2 must not capture or mark it seen
        dwell(2, gl[8], 3, "short_d2");
        dwell(0, gl[1], 6, "part_d0");
        dwell(1, gl[1], 6, "part_d1");
        for (int d = 3; d < ND; d++) dwell(d, gl[d], 6, $sformatf("part_d%0d", d));
        dwell(2, gl[10], 6, "close_d2");

        // Non-hex pattern on digit 5, then a good capture leaves bad flag set
        dwell(5, 7'h55, 6, "bad_d5");
        dwell(5, gl[9], 6, "good_d5");
        dwell(4, 7'h00, 6, "blank_d4");

        // Two anodes active: never captures, times out
        hold_raw(8'hFC, ~gl[3], 100, "multi_an");
        dwell(1, gl[3], 6, "after_to");

        // Reset on cycle 2 of a dwell on digit 3 drops the capture
        an_in  = 8'hF7;
        seg_in = ~gl[14];
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_dig", digits, 32'h0);
        chk("mid_rst_vld", 32'(digit_valid), 32'h0);
        chk("mid_rst_bad", 32'(bad_pattern), 32'h0);
        chk("mid_rst_to",  32'(scan_timeout), 32'h0);
        reset  = 1'b0;
        an_in  = 8'hFF;
        seg_in = 7'h7F;
        repeat (8) @(negedge clock);
        chk("mid_rst_nocap_dig", digits, 32'h0);
        chk("mid_rst_nocap_vld", 32'(digit_valid), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
